// File: rtl/button_repeat_ctrl.sv
// Plus/minus set-button conditioner: sync, debounce, press pulse, long-press hold and auto-repeat.
// Optional repeat acceleration is enabled by defining REPEAT_ACCEL_EN.
module button_repeat_ctrl #(
    parameter int DEBOUNCE    = 20,
    parameter int HOLD        = 500,
    parameter int REPEAT      = 100,
    parameter int FAST_REPEAT = 25,
    parameter int FAST_AFTER  = 8,
    parameter int WIDTH       = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic btn_plus,
    input  logic btn_minus,
    output logic pulse_up,
    output logic pulse_down,
    output logic hold_up,
    output logic hold_down
);

    localparam int N = 2;

    localparam logic [WIDTH-1:0] DB_LAST   = WIDTH'(DEBOUNCE - 1);
    localparam logic [WIDTH-1:0] HOLD_LAST = WIDTH'(HOLD - 1);
    localparam logic [WIDTH-1:0] REP_LAST  = WIDTH'(REPEAT - 1);

    if (DEBOUNCE < 1 || HOLD < 2 || REPEAT < 2 || FAST_REPEAT < 2 || FAST_AFTER < 0 ||
        (2 ** WIDTH) <= DEBOUNCE || (2 ** WIDTH) <= HOLD || (2 ** WIDTH) <= REPEAT ||
        (2 ** WIDTH) <= FAST_REPEAT) begin : gBadParams
        $error("button_repeat_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // Index 0 is the plus button, index 1 the minus button.
    logic [N-1:0]     w_raw;
    logic [N-1:0]     r_sync1;
    logic [N-1:0]     r_sync2;
    logic [N-1:0]     r_stable;
    logic [WIDTH-1:0] r_dbCnt [N];

    state_t           r_state     [N];
    state_t           w_stateNext [N];
    logic [WIDTH-1:0] r_tickCnt   [N];
    logic [WIDTH-1:0] w_tickNext  [N];
    logic [WIDTH-1:0] w_intervalLast [N];
    logic [N-1:0]     r_hold;
    logic [N-1:0]     w_holdNext;
    logic [N-1:0]     r_pulse;
    logic [N-1:0]     w_pulseNext;
    logic             w_lockout;

`ifdef REPEAT_ACCEL_EN
    localparam int RCW = (FAST_AFTER < 1) ? 1 : $clog2(FAST_AFTER + 1);
    localparam logic [RCW-1:0] REP_SAT   = RCW'(FAST_AFTER);
    localparam logic [WIDTH-1:0] FAST_LAST = WIDTH'(FAST_REPEAT - 1);

    logic [RCW-1:0] r_repCnt  [N];
    logic [RCW-1:0] w_repNext [N];
`endif

    assign w_raw = {btn_minus, btn_plus};

    // Debounce only counts while the synced level disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < N; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (enable) begin
                    if (r_dbCnt[i] == DB_LAST) begin
                        r_stable[i] <= r_sync2[i];
                        r_dbCnt[i]  <= '0;
                    end else begin
                        r_dbCnt[i] <= r_dbCnt[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hold  <= '0;
            r_pulse <= '0;
            for (int i = 0; i < N; i++) begin
                r_state[i]   <= S_IDLE;
                r_tickCnt[i] <= '0;
`ifdef REPEAT_ACCEL_EN
                r_repCnt[i]  <= '0;
`endif
            end
        end else begin
            r_hold  <= w_holdNext;
            r_pulse <= w_pulseNext;
            for (int i = 0; i < N; i++) begin
                r_state[i]   <= w_stateNext[i];
                r_tickCnt[i] <= w_tickNext[i];
`ifdef REPEAT_ACCEL_EN
                r_repCnt[i]  <= w_repNext[i];
`endif
            end
        end
    end

    // Press is taken on any clk; hold and repeat timing advance only on enable ticks.
    always_comb begin
        w_pulseNext = '0;
        w_holdNext  = r_hold;
        for (int i = 0; i < N; i++) begin
            w_stateNext[i] = r_state[i];
            w_tickNext[i]  = r_tickCnt[i];
`ifdef REPEAT_ACCEL_EN
            w_repNext[i]      = r_repCnt[i];
            w_intervalLast[i] = (r_repCnt[i] < REP_SAT) ? REP_LAST : FAST_LAST;
`else
            w_intervalLast[i] = REP_LAST;
`endif
            case (r_state[i])
                S_IDLE: begin
                    if (r_stable[i]) begin
                        w_pulseNext[i] = 1'b1;
                        w_tickNext[i]  = '0;
                        w_stateNext[i] = S_WAIT;
                    end
                end
                S_WAIT, S_REPEAT: begin
                    if (!r_stable[i]) begin
                        w_stateNext[i] = S_IDLE;
                        w_holdNext[i]  = 1'b0;
                        w_tickNext[i]  = '0;
`ifdef REPEAT_ACCEL_EN
                        w_repNext[i]   = '0;
`endif
                    end else if (enable) begin
                        if (r_state[i] == S_WAIT && r_tickCnt[i] == HOLD_LAST) begin
                            w_holdNext[i]  = 1'b1;
                            w_pulseNext[i] = 1'b1;
                            w_tickNext[i]  = '0;
                            w_stateNext[i] = S_REPEAT;
`ifdef REPEAT_ACCEL_EN
                            w_repNext[i]   = (REP_SAT == '0) ? '0 : RCW'(1);
`endif
                        end else if (r_state[i] == S_REPEAT && r_tickCnt[i] == w_intervalLast[i]) begin
                            w_pulseNext[i] = 1'b1;
                            w_tickNext[i]  = '0;
`ifdef REPEAT_ACCEL_EN
                            if (r_repCnt[i] < REP_SAT) begin
                                w_repNext[i] = r_repCnt[i] + RCW'(1);
                            end
`endif
                        end else begin
                            w_tickNext[i] = r_tickCnt[i] + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    w_stateNext[i] = S_IDLE;
                    w_holdNext[i]  = 1'b0;
                    w_tickNext[i]  = '0;
                end
            endcase
        end
    end

    // Both buttons accepted as pressed is meaningless, so all outputs are silenced.
    assign w_lockout  = r_stable[0] & r_stable[1];
    assign pulse_up   = r_pulse[0] & ~w_lockout;
    assign pulse_down = r_pulse[1] & ~w_lockout;
    assign hold_up    = r_hold[0]  & ~w_lockout;
    assign hold_down  = r_hold[1]  & ~w_lockout;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Directed per-cycle vector bench for button_repeat_ctrl (small timing parameters).
// Expectations follow REPEAT_ACCEL_EN when the bench is built with that macro.
module tb_button_repeat_ctrl;

    localparam int DEB  = 4;
    localparam int HLD  = 10;
    localparam int REP  = 3;
    localparam int FREP = 2;
    localparam int FAFT = 2;
    localparam int W    = 4;
    localparam int MAXV = 128;

    // Output bit positions inside expOut.
    localparam int PU = 3;
    localparam int PD = 2;
    localparam int HU = 1;
    localparam int HD = 0;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic btn_plus;
    logic btn_minus;
    logic pulse_up;
    logic pulse_down;
    logic hold_up;
    logic hold_down;

    typedef struct {
        logic       plus;
        logic       minus;
        logic       en;
        logic       rstn;
        logic [3:0] expOut;
    } vec_t;

    vec_t vecs [MAXV];
    int   nVec;
    int   checks = 0;
    int   passes = 0;

    button_repeat_ctrl #(
        .DEBOUNCE   (DEB),
        .HOLD       (HLD),
        .REPEAT     (REP),
        .FAST_REPEAT(FREP),
        .FAST_AFTER (FAFT),
        .WIDTH      (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .btn_plus  (btn_plus),
        .btn_minus (btn_minus),
        .pulse_up  (pulse_up),
        .pulse_down(pulse_down),
        .hold_up   (hold_up),
        .hold_down (hold_down)
    );

    always #5 clk = ~clk;

    function automatic void newScenario(input int n);
        nVec = n;
        for (int i = 0; i < MAXV; i++) begin
            vecs[i].plus   = 1'b0;
            vecs[i].minus  = 1'b0;
            vecs[i].en     = 1'b1;
            vecs[i].rstn   = 1'b1;
            vecs[i].expOut = 4'b0000;
        end
    endfunction

    function automatic void setPlus(input int from, input int to);
        for (int i = from; i <= to; i++) vecs[i].plus = 1'b1;
    endfunction

    function automatic void setMinus(input int from, input int to);
        for (int i = from; i <= to; i++) vecs[i].minus = 1'b1;
    endfunction

    function automatic void expRange(input int bitIdx, input int from, input int to, input int step);
        for (int i = from; i <= to; i += step) vecs[i].expOut[bitIdx] = 1'b1;
    endfunction

    task automatic checkOutput(input string name, input int cyc, input logic [3:0] expOut);
        logic [3:0] act;
        act = {pulse_up, pulse_down, hold_up, hold_down};
        checks++;
        if (act === expOut) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s cycle %0d: got pu/pd/hu/hd=%b, expected %b", name, cyc, act, expOut);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        btn_plus  = v.plus;
        btn_minus = v.minus;
        enable    = v.en;
        reset_n   = v.rstn;
    endtask

    task automatic applyReset(input string name);
        reset_n   = 1'b0;
        btn_plus  = 1'b0;
        btn_minus = 1'b0;
        enable    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput(name, -1, 4'b0000);
        reset_n = 1'b1;
    endtask

    // Cycle k compares the state after edge k, then drives the inputs for edge k+1.
    task automatic runScenario(input string name);
        for (int k = 0; k < nVec; k++) begin
            @(posedge clk);
            #1;
            checkOutput(name, k, vecs[k].expOut);
            applyStimulus(vecs[k]);
        end
    endtask

    initial begin
        applyReset("reset_init");

        // Short press: one pulse at 2 sync + 4 debounce + 1.
        newScenario(25);
        setPlus(0, 7);
        expRange(PU, 7, 7, 1);
        runScenario("short_press");
        applyReset("reset_after_press");

        // Three-cycle glitch never reaches the debounced level.
        newScenario(16);
        setPlus(0, 2);
        runScenario("glitch");
        applyReset("reset_after_glitch");

        // Long press, released at cycle 40; debounced release at 46, hold drops at 47.
        newScenario(56);
        setPlus(0, 39);
        expRange(PU, 7, 7, 1);
        expRange(PU, 17, 17, 1);
        expRange(HU, 17, 46, 1);
`ifdef REPEAT_ACCEL_EN
        expRange(PU, 20, 20, 1);
        expRange(PU, 22, 46, 2);
`else
        expRange(PU, 20, 44, 3);
`endif
        runScenario("long_press");
        applyReset("reset_after_long");

        // Both pressed together; minus released at 30, its debounced level falls at 36.
        newScenario(60);
        setPlus(0, 59);
        setMinus(0, 29);
        expRange(HU, 36, 59, 1);
        expRange(HD, 36, 36, 1);
`ifdef REPEAT_ACCEL_EN
        expRange(PU, 36, 58, 2);
        expRange(PD, 36, 36, 1);
`else
        expRange(PU, 38, 59, 3);
`endif
        runScenario("lockout");
        applyReset("reset_after_lockout");

        // Reset pulse sampled at edge 20 with plus still held; fresh press at 27.
        newScenario(40);
        setPlus(0, 39);
        vecs[19].rstn = 1'b0;
        expRange(PU, 7, 7, 1);
        expRange(PU, 17, 17, 1);
        expRange(HU, 17, 19, 1);
        expRange(PU, 27, 27, 1);
        expRange(PU, 37, 37, 1);
        expRange(HU, 37, 39, 1);
        runScenario("mid_reset");
        applyReset("reset_after_mid");

        // Enable only every fourth clk: ticks land on edges 4, 8, 12, ...
        newScenario(96);
        setPlus(0, 95);
        for (int k = 0; k < 96; k++) vecs[k].en = ((k % 4) == 3);
        expRange(PU, 17, 17, 1);
        expRange(PU, 56, 56, 1);
        expRange(PU, 68, 68, 1);
        expRange(HU, 56, 95, 1);
`ifdef REPEAT_ACCEL_EN
        expRange(PU, 76, 92, 8);
`else
        expRange(PU, 80, 92, 12);
`endif
        runScenario("slow_enable");
        applyReset("reset_after_slow");

        // Minus alone exercises the down path.
        newScenario(22);
        setMinus(0, 21);
        expRange(PD, 7, 7, 1);
        expRange(PD, 17, 17, 1);
        expRange(PD, 20, 20, 1);
        expRange(HD, 17, 21, 1);
        runScenario("minus_hold");
        applyReset("reset_final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
